addr_seq: RTL

Addressing-mode sequencer for the 65C816 core's address generator. Once per instruction it takes an addressing-mode code and drives the generator's control inputs cycle by cycle: `ADDR_CTRL`, `IND_CTRL` and `LOAD_PC`. It also tells the bus mux which address source to use on each step, inserts the conditional penalty cycles, and signals completion to the main instruction decoder.

---
 rtl/addr_seq_if.sv | 29 ++
 rtl/addr_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/addr_seq_if.sv
// Control/handshake bundle between the instruction decoder, the address
// generator and the addressing-mode sequencer.
interface addr_seq_if;
   logic       EN;
   logic       START;
   logic [2:0] MODE;
   logic       DL_ZERO;
   logic       X16;
   logic       E6502;
   logic       TAKEN;
   logic       AAL_CARRY;
   logic       JUMP_NOOFL;
   logic [7:0] ADDR_CTRL;
   logic [1:0] IND_CTRL;
   logic [2:0] LOAD_PC;
   logic [1:0] ADDR_SEL;
   logic       BUSY;
   logic       DONE;

   modport master (
      output EN, START, MODE, DL_ZERO, X16, E6502, TAKEN, AAL_CARRY, JUMP_NOOFL,
      input  ADDR_CTRL, IND_CTRL, LOAD_PC, ADDR_SEL, BUSY, DONE
   );

   modport slave (
      input  EN, START, MODE, DL_ZERO, X16, E6502, TAKEN, AAL_CARRY, JUMP_NOOFL,
      output ADDR_CTRL, IND_CTRL, LOAD_PC, ADDR_SEL, BUSY, DONE
   );
endinterface

// File: rtl/addr_seq.sv
// 65C816 addressing-mode sequencer: steps the address generator through one
// addressing mode per instruction, inserting conditional penalty cycles.
module addr_seq (
   input  logic        CLK,
   input  logic        RST,
   addr_seq_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, S1, S2, S3, S4} state_t;
   typedef enum logic [2:0] {
      M_IMM, M_DP, M_DPX, M_ABS, M_ABSX, M_ABSY, M_LONG, M_REL
   } mode_t;

   state_t state, next_state;
   mode_t  mode_q;
   logic   dl_zero_q, x16_q, e6502_q, taken_q;

   logic [2:0] aal, aah, load_pc;
   logic [1:0] abs_sel, ind, addr_sel;
   logic       last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else if (bus.EN) begin
         state <= next_state;
      end
   end

   // Mode and flags are captured only when a sequence is accepted.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mode_q    <= M_IMM;
         dl_zero_q <= 1'b0;
         x16_q     <= 1'b0;
         e6502_q   <= 1'b0;
         taken_q   <= 1'b0;
      end else if (bus.EN && state == IDLE && bus.START) begin
         mode_q    <= mode_t'(bus.MODE);
         dl_zero_q <= bus.DL_ZERO;
         x16_q     <= bus.X16;
         e6502_q   <= bus.E6502;
         taken_q   <= bus.TAKEN;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      aal        = 3'b111;
      aah        = 3'b111;
      abs_sel    = 2'b00;
      ind        = 2'b00;
      load_pc    = 3'b000;
      addr_sel   = 2'b00;
      last       = 1'b0;
      next_state = state;

      unique case (state)
         IDLE: begin
            if (bus.START) next_state = S1;
         end

         S1: begin
            next_state = S2;
            case (mode_q)
               M_IMM: begin
                  load_pc = 3'b001;
                  last    = 1'b1;
               end
               M_DP, M_DPX: begin
                  aal     = 3'b101;
                  aah     = 3'b101;
                  load_pc = 3'b001;
                  last    = (mode_q == M_DP) && dl_zero_q;
                  // Direct page aligned: the extra D-add cycle is skipped.
                  if (dl_zero_q) next_state = S3;
               end
               M_REL: begin
                  load_pc = 3'b001;
                  last    = !taken_q;
               end
               default: begin
                  aal     = 3'b010;
                  load_pc = 3'b001;
               end
            endcase
         end

         S2: begin
            next_state = S3;
            case (mode_q)
               M_DPX: ;
               M_ABS, M_ABSX, M_ABSY: begin
                  aah     = 3'b010;
                  abs_sel = 2'b11;
                  load_pc = 3'b001;
                  last    = (mode_q == M_ABS);
               end
               M_LONG: begin
                  aah     = 3'b010;
                  load_pc = 3'b001;
               end
               M_REL: begin
                  load_pc = 3'b100;
                  // Emulation-mode page cross on a taken branch costs a cycle.
                  last    = !(e6502_q && !bus.JUMP_NOOFL);
               end
               default: last = 1'b1;
            endcase
         end

         S3: begin
            next_state = S4;
            case (mode_q)
               M_DPX: begin
                  aal      = 3'b100;
                  aah      = 3'b100;
                  addr_sel = 2'b01;
                  last     = 1'b1;
               end
               M_ABSX, M_ABSY: begin
                  aal  = 3'b001;
                  ind  = (mode_q == M_ABSY) ? 2'b01 : 2'b00;
                  last = !(bus.AAL_CARRY || x16_q);
               end
               M_LONG: begin
                  abs_sel = 2'b01;
                  load_pc = 3'b001;
                  last    = 1'b1;
               end
               default: last = 1'b1;
            endcase
         end

         S4: begin
            aah  = 3'b001;
            ind  = (mode_q == M_ABSY) ? 2'b01 : 2'b00;
            last = 1'b1;
         end

         default: next_state = IDLE;
      endcase

      if (last) next_state = IDLE;
   end

   assign bus.ADDR_CTRL = {aal, aah, abs_sel};
   assign bus.IND_CTRL  = ind;
   assign bus.LOAD_PC   = load_pc;
   assign bus.ADDR_SEL  = addr_sel;
   assign bus.BUSY      = (state != IDLE);
   assign bus.DONE      = (state != IDLE) && last;

endmodule
